hwpe_ctrl_regfile_bist_mp: RTL and testbench
============================================

Name: hwpe_ctrl_regfile_bist_mp

Overview:
- Multi-read-port, byte-enabled, flop-based register file for the HWPE control slave on FPGA targets.
- Generalises the single-read-port regfile with external BIST muxing:
  - NB_RPORTS independent registered read ports.
  - An internal March BIST engine, started by one pulse, that reports pass/fail and the first failing address.
- Sits between the hwpe_ctrl slave register logic and the job/context register array; MemContent feeds the datapath.

Parameters:
- ADDR_WIDTH, 5, address bits; depth D = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, word width; multiple of 8.
- NUM_BYTE, DATA_WIDTH/8, byte lanes per word.
- NB_RPORTS, 2, number of independent read ports (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear of array, read data and BIST status.
- ReadEnable  in  NB_RPORTS  per-port read request.
- ReadAddr  in  NB_RPORTS x ADDR_WIDTH  per-port read address.
- ReadData  out  NB_RPORTS x DATA_WIDTH  per-port registered read data.
- WriteEnable  in  1  write request.
- WriteAddr  in  ADDR_WIDTH  write address.
- WriteData  in  NUM_BYTE x 8  write data.
- WriteBE  in  NUM_BYTE  byte enables.
- MemContent  out  D x DATA_WIDTH  live array contents (false path).
- bist_start  in  1  single-cycle pulse; starts BIST from IDLE.
- bist_busy  out  1  BIST running.
- bist_done  out  1  sticky; BIST completed.
- bist_fail  out  1  sticky; at least one mismatch detected.
- bist_fail_addr  out  ADDR_WIDTH  address of first mismatch.

Behaviour:
- Reset (async, rst_n=0) clears:
  - all array entries to 0;
  - all ReadData to 0;
  - bist_busy, bist_done, bist_fail and bist_fail_addr to 0;
  - FSM to IDLE.
- Write: with WriteEnable=1, each byte lane with WriteBE[b]=1 is updated at the clk edge. Lanes with BE=0 hold their value.
- Read: with ReadEnable[p]=1, ReadData[p] = array[ReadAddr[p]] sampled at the edge, i.e. 1-cycle latency. ReadData[p] holds its value when ReadEnable[p]=0.
- Read/write same address, same cycle: read returns the OLD data; the new data is visible on the next read.
- Multiple ports may read the same address in the same cycle; each gets identical data.
- clear=1:
  - zeroes array and all ReadData;
  - drops done, fail and fail_addr;
  - aborts BIST to IDLE;
  - has priority over write, read and bist_start.
- BIST FSM states: IDLE, W0_UP, R0W1_UP, R1W0_DN, R0_UP, DONE.
  - IDLE: bist_start=1 -> W0_UP, addr=0, busy=1, done=0, fail=0, fail_addr=0.
  - W0_UP: writes 0 to addr, 1 cycle per address, ascending. After D-1 -> R0W1_UP, addr=0.
  - R0W1_UP: 2 cycles per address, ascending. Cycle A compares array[addr] against all-0; cycle B writes all-1. After D-1 -> R1W0_DN, addr=D-1.
  - R1W0_DN: 2 cycles per address, descending. Compares against all-1, then writes all-0. After addr 0 -> R0_UP, addr=0.
  - R0_UP: 1 cycle per address, compares against all-0. After D-1 -> DONE.
  - DONE: busy=0, done=1 (sticky) -> IDLE in the same cycle. Total busy duration = 6*D cycles.
- Mismatch handling: any compare mismatch sets fail=1. fail_addr is captured only on the first mismatch; later mismatches do not update it. BIST does not stop on failure.
- While busy:
  - functional WriteEnable and ReadEnable are ignored;
  - ReadData holds its value;
  - bist_start is ignored.
- After a passing BIST, array contents are all 0.
- bist_start while done=1 (in IDLE) restarts BIST and clears done and fail.
- Reset mid-BIST aborts immediately to reset values.

Optional Feature:
- Macro: HWPE_REGFILE_BIST_EN.
- Defined: the full BIST FSM is present, as specified above.
- Undefined:
  - no BIST logic is generated;
  - bist_start is ignored;
  - bist_busy, bist_done and bist_fail are tied to 0, and bist_fail_addr is tied to 0;
  - functional ports are always active.

Test Plan:
- Byte-enable write: ADDR_WIDTH=5, NB_RPORTS=2. Write addr 3 = 0xDEADBEEF with BE=1111, then 0x11223344 with BE=0101. Read port0 addr 3 -> 0xDE22BE44 one cycle after ReadEnable.
- Same-cycle read/write: addr 7 holds 0xA5A5A5A5. Write 0x0 to addr 7 with a same-cycle read on both ports -> both ReadData = 0xA5A5A5A5. Next read -> 0x0. MemContent[7] = 0 after the edge.
- Clear priority: write addr 1 = 0xFFFFFFFF, then clear=1 together with a write of 0x12345678 to addr 2. Next cycle: MemContent all 0, ReadData all 0.
- BIST pass: pulse bist_start with D=32.
  - bist_busy is high for exactly 192 cycles; writes and reads issued meanwhile have no effect.
  - Then bist_done=1, bist_fail=0, MemContent all 0.
- BIST fail: bench forces bit 0 of entries 5 and 9 stuck-at-1, then pulses bist_start -> bist_done=1, bist_fail=1, bist_fail_addr=5.
- Abort and macro off:
  - clear at cycle 50 of BIST -> busy=0, done=0, fail=0 next cycle.
  - Build without HWPE_REGFILE_BIST_EN: bist_start pulse -> busy, done and fail stay 0; functional read/write work in the same cycle.

Source files
------------

// File: rtl/hwpe_ctrl_regfile_bist_mp.sv
// Multi-read-port, byte-enabled, flop-based register file for the HWPE control slave.
// NB_RPORTS registered read ports (1-cycle latency), one byte-enabled write port.
// Optional March BIST engine (W0 up, R0W1 up, R1W0 down, R0 up), enabled by defining
// HWPE_REGFILE_BIST_EN. Without it the bist_* outputs are tied to 0 and bist_start is unused.
// MemContent exposes the live array and is meant to be a false path.

module hwpe_ctrl_regfile_bist_mp #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_BYTE   = DATA_WIDTH / 8,
    parameter int unsigned NB_RPORTS  = 2
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         clear,
    input  logic [NB_RPORTS-1:0]                         ReadEnable,
    input  logic [NB_RPORTS-1:0][ADDR_WIDTH-1:0]         ReadAddr,
    output logic [NB_RPORTS-1:0][DATA_WIDTH-1:0]         ReadData,
    input  logic                                         WriteEnable,
    input  logic [ADDR_WIDTH-1:0]                        WriteAddr,
    input  logic [NUM_BYTE-1:0][7:0]                     WriteData,
    input  logic [NUM_BYTE-1:0]                          WriteBE,
    output logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]   MemContent,
    input  logic                                         bist_start,
    output logic                                         bist_busy,
    output logic                                         bist_done,
    output logic                                         bist_fail,
    output logic [ADDR_WIDTH-1:0]                        bist_fail_addr
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_content;

    // Shared write port, owned by the BIST engine while it runs
    logic                  busy;
    logic                  bist_we;
    logic [ADDR_WIDTH-1:0] bist_addr;
    logic [DATA_WIDTH-1:0] bist_wdata;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NUM_BYTE-1:0]   wr_be;

    // Select the write source: BIST while busy, functional port otherwise
    always_comb begin
        wr_en   = WriteEnable;
        wr_addr = WriteAddr;
        wr_data = WriteData;
        wr_be   = WriteBE;
        if (busy) begin
            wr_en   = bist_we;
            wr_addr = bist_addr;
            wr_data = bist_wdata;
            wr_be   = '1;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [DATA_WIDTH-1:0] word_q;

        // Per-word storage with byte-lane write enables
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_q <= '0;
            end else if (clear) begin
                word_q <= '0;
            end else if (wr_en && (wr_addr == ADDR_WIDTH'(i))) begin
                for (int b = 0; b < NUM_BYTE; b++) begin
                    if (wr_be[b]) begin
                        word_q[8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end

        assign mem_content[i] = word_q;
    end

    assign MemContent = mem_content;

    for (genvar p = 0; p < NB_RPORTS; p++) begin : g_rport
        logic [DATA_WIDTH-1:0] rdata_q;

        // Registered read; samples pre-write contents, holds when idle or during BIST
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q <= '0;
            end else if (clear) begin
                rdata_q <= '0;
            end else if (ReadEnable[p] && !busy) begin
                rdata_q <= mem_content[ReadAddr[p]];
            end
        end

        assign ReadData[p] = rdata_q;
    end

`ifdef HWPE_REGFILE_BIST_EN

    localparam logic [ADDR_WIDTH-1:0] AddrMax = '1;

    typedef enum logic [2:0] {
        StIdle,
        StW0Up,
        StR0W1Up,
        StR1W0Dn,
        StR0Up,
        StDone
    } bist_state_e;

    bist_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    // phase_q: 0 = compare cycle, 1 = write cycle of the two-cycle March elements
    logic                  phase_q, phase_d;
    logic                  done_q, fail_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q;

    logic                  cmp_en;
    logic [DATA_WIDTH-1:0] cmp_exp;
    logic                  mismatch;

    // FSM state, address and phase registers; clear aborts to idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            phase_q <= 1'b0;
        end else if (clear) begin
            state_q <= StIdle;
            addr_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
        end
    end

    // Next-state: walk the March elements over the whole address space
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        case (state_q)
            StIdle: begin
                if (bist_start) begin
                    state_d = StW0Up;
                    addr_d  = '0;
                    phase_d = 1'b0;
                end
            end
            StW0Up: begin
                if (addr_q == AddrMax) begin
                    state_d = StR0W1Up;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StR0W1Up: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (addr_q == AddrMax) begin
                        state_d = StR1W0Dn;
                        addr_d  = AddrMax;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            StR1W0Dn: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (addr_q == '0) begin
                        state_d = StR0Up;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q - 1'b1;
                    end
                end
            end
            StR0Up: begin
                if (addr_q == AddrMax) begin
                    state_d = StDone;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: array write / compare controls per state and phase
    always_comb begin
        busy       = 1'b0;
        bist_we    = 1'b0;
        bist_wdata = '0;
        cmp_en     = 1'b0;
        cmp_exp    = '0;
        case (state_q)
            StW0Up: begin
                busy    = 1'b1;
                bist_we = 1'b1;
            end
            StR0W1Up: begin
                busy = 1'b1;
                if (phase_q) begin
                    bist_we    = 1'b1;
                    bist_wdata = '1;
                end else begin
                    cmp_en = 1'b1;
                end
            end
            StR1W0Dn: begin
                busy = 1'b1;
                if (phase_q) begin
                    bist_we = 1'b1;
                end else begin
                    cmp_en  = 1'b1;
                    cmp_exp = '1;
                end
            end
            StR0Up: begin
                busy   = 1'b1;
                cmp_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign bist_addr = addr_q;
    assign mismatch  = cmp_en && (mem_content[addr_q] != cmp_exp);

    // Sticky status; fail_addr latches only the first mismatch of a run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
        end else if (clear) begin
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
        end else if ((state_q == StIdle) && bist_start) begin
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
        end else begin
            if ((state_q == StR0Up) && (addr_q == AddrMax)) begin
                done_q <= 1'b1;
            end
            if (mismatch) begin
                fail_q <= 1'b1;
                if (!fail_q) begin
                    fail_addr_q <= addr_q;
                end
            end
        end
    end

    assign bist_busy      = busy;
    assign bist_done      = done_q;
    assign bist_fail      = fail_q;
    assign bist_fail_addr = fail_addr_q;

`else

    logic unused_bist_start;
    assign unused_bist_start = bist_start;

    assign busy           = 1'b0;
    assign bist_we        = 1'b0;
    assign bist_addr      = '0;
    assign bist_wdata     = '0;
    assign bist_busy      = 1'b0;
    assign bist_done      = 1'b0;
    assign bist_fail      = 1'b0;
    assign bist_fail_addr = '0;

`endif

endmodule

// File: tb/tb_hwpe_ctrl_regfile_bist_mp.sv
// Directed bench for hwpe_ctrl_regfile_bist_mp (ADDR_WIDTH=5, DATA_WIDTH=32, NB_RPORTS=2).
// BIST scenarios are compiled only when HWPE_REGFILE_BIST_EN is defined; otherwise the
// tied-off BIST outputs are checked instead.

module tb_hwpe_ctrl_regfile_bist_mp;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic [1:0]        ReadEnable;
    logic [1:0][4:0]   ReadAddr;
    logic [1:0][31:0]  ReadData;
    logic              WriteEnable;
    logic [4:0]        WriteAddr;
    logic [3:0][7:0]   WriteData;
    logic [3:0]        WriteBE;
    logic [31:0][31:0] MemContent;
    logic              bist_start;
    logic              bist_busy;
    logic              bist_done;
    logic              bist_fail;
    logic [4:0]        bist_fail_addr;

    int total = 0;
    int bad   = 0;

    hwpe_ctrl_regfile_bist_mp #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32),
        .NUM_BYTE   (4),
        .NB_RPORTS  (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .ReadEnable     (ReadEnable),
        .ReadAddr       (ReadAddr),
        .ReadData       (ReadData),
        .WriteEnable    (WriteEnable),
        .WriteAddr      (WriteAddr),
        .WriteData      (WriteData),
        .WriteBE        (WriteBE),
        .MemContent     (MemContent),
        .bist_start     (bist_start),
        .bist_busy      (bist_busy),
        .bist_done      (bist_done),
        .bist_fail      (bist_fail),
        .bist_fail_addr (bist_fail_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge, the DUT samples them on the next rising edge
    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        WriteEnable = 1'b1;
        WriteAddr   = a;
        WriteData   = d;
        WriteBE     = be;
        @(negedge clk);
        WriteEnable = 1'b0;
    endtask

    initial begin
        int cnt;
        rst_n       = 1'b0;
        clear       = 1'b0;
        ReadEnable  = '0;
        ReadAddr    = '0;
        WriteEnable = 1'b0;
        WriteAddr   = '0;
        WriteData   = '0;
        WriteBE     = '0;
        bist_start  = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_rdata0", ReadData[0], 64'h0);
        chk("rst_rdata1", ReadData[1], 64'h0);
        chk("rst_mem_zero", (MemContent === '0), 64'h1);
        chk("rst_busy", bist_busy, 64'h0);
        chk("rst_done", bist_done, 64'h0);
        chk("rst_fail", bist_fail, 64'h0);
        chk("rst_fail_addr", bist_fail_addr, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Byte-enable write: DEADBEEF then 11223344 on lanes 0 and 2
        wr(5'd3, 32'hDEADBEEF, 4'b1111);
        wr(5'd3, 32'h11223344, 4'b0101);
        chk("be_mem3", MemContent[3], 64'hDE22BE44);
        ReadEnable[0] = 1'b1;
        ReadAddr[0]   = 5'd3;
        @(negedge clk);
        ReadEnable[0] = 1'b0;
        chk("be_rdata0", ReadData[0], 64'hDE22BE44);
        ReadAddr[0] = 5'd0;
        @(negedge clk);
        chk("hold_rdata0", ReadData[0], 64'hDE22BE44);

        // Same-cycle read/write returns old data on both ports
        wr(5'd7, 32'hA5A5A5A5, 4'b1111);
        ReadEnable = 2'b11;
        ReadAddr   = {5'd7, 5'd7};
        wr(5'd7, 32'h00000000, 4'b1111);
        ReadEnable = 2'b00;
        chk("rw_old_p0", ReadData[0], 64'hA5A5A5A5);
        chk("rw_old_p1", ReadData[1], 64'hA5A5A5A5);
        chk("rw_mem7", MemContent[7], 64'h0);
        ReadEnable[0] = 1'b1;
        @(negedge clk);
        ReadEnable[0] = 1'b0;
        chk("rw_new_p0", ReadData[0], 64'h0);
        chk("rw_hold_p1", ReadData[1], 64'hA5A5A5A5);

        // Independent ports at different addresses
        wr(5'd10, 32'h0BADF00D, 4'b1111);
        wr(5'd20, 32'hCAFEF00D, 4'b1111);
        ReadEnable = 2'b11;
        ReadAddr   = {5'd10, 5'd20};
        @(negedge clk);
        ReadEnable = 2'b00;
        chk("mp_p0", ReadData[0], 64'hCAFEF00D);
        chk("mp_p1", ReadData[1], 64'h0BADF00D);

        // Clear wins over a simultaneous write and read
        wr(5'd1, 32'hFFFFFFFF, 4'b1111);
        clear      = 1'b1;
        ReadEnable = 2'b11;
        ReadAddr   = {5'd1, 5'd1};
        wr(5'd2, 32'h12345678, 4'b1111);
        clear      = 1'b0;
        ReadEnable = 2'b00;
        chk("clr_mem_zero", (MemContent === '0), 64'h1);
        chk("clr_rdata0", ReadData[0], 64'h0);
        chk("clr_rdata1", ReadData[1], 64'h0);

`ifdef HWPE_REGFILE_BIST_EN
        // BIST pass: 6*32 busy cycles, functional traffic and restarts ignored
        wr(5'd4, 32'h600DF00D, 4'b1111);
        ReadEnable = 2'b11;
        ReadAddr   = {5'd4, 5'd4};
        @(negedge clk);
        ReadEnable = 2'b00;
        chk("pre_bist_rd", ReadData[0], 64'h600DF00D);
        bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
        chk("bist_busy_rise", bist_busy, 64'h1);
        chk("bist_done_low", bist_done, 64'h0);
        cnt = 0;
        while (bist_busy && cnt < 1000) begin
            cnt++;
            if (cnt == 100) bist_start = 1'b1;
            WriteEnable = 1'b1;
            WriteAddr   = 5'd6;
            WriteData   = 32'hFFFFFFFF;
            WriteBE     = 4'b1111;
            ReadEnable  = 2'b11;
            ReadAddr    = {5'd6, 5'd6};
            @(negedge clk);
            bist_start = 1'b0;
        end
        WriteEnable = 1'b0;
        ReadEnable  = 2'b00;
        chk("bist_busy_cycles", cnt, 64'd192);
        chk("bist_pass_done", bist_done, 64'h1);
        chk("bist_pass_fail", bist_fail, 64'h0);
        chk("bist_pass_mem_zero", (MemContent === '0), 64'h1);
        chk("bist_rd_hold_p0", ReadData[0], 64'h600DF00D);
        chk("bist_rd_hold_p1", ReadData[1], 64'h600DF00D);
        @(negedge clk);
        chk("bist_done_sticky", bist_done, 64'h1);

        // BIST fail: entries 5 and 9 stuck with bit 0 high; first failure reported is 5
        force dut.g_word[5].word_q = 32'h00000001;
        force dut.g_word[9].word_q = 32'h00000001;
        bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
        chk("restart_done_clr", bist_done, 64'h0);
        cnt = 0;
        while (bist_busy && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        chk("fail_busy_cycles", cnt, 64'd192);
        chk("fail_done", bist_done, 64'h1);
        chk("fail_flag", bist_fail, 64'h1);
        chk("fail_addr", bist_fail_addr, 64'd5);
        release dut.g_word[5].word_q;
        release dut.g_word[9].word_q;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_status_done", bist_done, 64'h0);
        chk("clr_status_fail", bist_fail, 64'h0);
        chk("clr_status_addr", bist_fail_addr, 64'h0);

        // Clear 50 cycles into a run aborts it
        bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
        repeat (49) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("abort_busy", bist_busy, 64'h0);
        chk("abort_done", bist_done, 64'h0);
        chk("abort_fail", bist_fail, 64'h0);
        @(negedge clk);
        chk("abort_stays_idle", bist_busy, 64'h0);

        // Asynchronous reset in the middle of a run
        bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_busy", bist_busy, 64'h0);
        chk("rstmid_done", bist_done, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_idle", bist_busy, 64'h0);
`else
        // BIST compiled out: start is ignored and functional ports stay live
        wr(5'd20, 32'hCAFEF00D, 4'b1111);
        bist_start    = 1'b1;
        ReadEnable[0] = 1'b1;
        ReadAddr[0]   = 5'd20;
        wr(5'd12, 32'h12121212, 4'b1111);
        bist_start    = 1'b0;
        ReadEnable[0] = 1'b0;
        chk("off_busy", bist_busy, 64'h0);
        chk("off_done", bist_done, 64'h0);
        chk("off_fail", bist_fail, 64'h0);
        chk("off_rdata0", ReadData[0], 64'hCAFEF00D);
        chk("off_mem12", MemContent[12], 64'h12121212);
        @(negedge clk);
        chk("off_busy_later", bist_busy, 64'h0);
        chk("off_fail_addr", bist_fail_addr, 64'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
